// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with registered ready and NOP bubbles.
// Define PIPE_SKID_STATS_EN to add the stall_cnt / bubble_cnt counters.
module pipe_skid_stage #(
  parameter int          DATA_W    = 160,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // out_data doubles as the main entry; it holds NOP_VALUE when empty
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= NOP_VALUE;
      in_ready  <= 1'b1;
      skid      <= NOP_VALUE;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (in_xfer) begin
            skid     <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (out_xfer) begin
            out_data  <= NOP_VALUE;
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_data <= skid;
            skid     <= NOP_VALUE;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_data  <= NOP_VALUE;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  // counters ignore flush so redirect cost stays visible
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)
        stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid && out_ready)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus randomized traffic
// checked against a queue-based model of the held beats.
module tb_pipe_skid_stage;

  localparam int W = 160;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic [31:0]  stall_m;
  logic [31:0]  bubble_m;

  pipe_skid_stage #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One clock edge; the model holds up to two beats in arrival order.
  task automatic tick();
    int sz;
    bit ox;
    bit ix;
    sz = q.size();
    @(posedge clk);
    if (rst) begin
      q.delete();
      stall_m  = '0;
      bubble_m = '0;
    end else begin
      if (sz > 0 && !out_ready) stall_m = stall_m + 32'd1;
      if (sz == 0 && out_ready) bubble_m = bubble_m + 32'd1;
      if (flush) begin
        q.delete();
      end else begin
        ox = (sz > 0) && out_ready;
        ix = in_valid && (sz < 2);
        if (ox) void'(q.pop_front());
        if (ix) q.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 1; out_ready = 1;
    in_data = W'(32'hDEAD);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: valid=%b ready=%b data=%h want 0 1 0",
               out_valid, in_ready, out_data);
    end
    rst = 0;
  endtask

  task automatic test_streaming();
    do_reset();
    in_valid = 1; out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      in_data = W'(k);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(k) || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream%0d: valid=%b ready=%b data=%h want 1 1 %0d",
                 k, out_valid, in_ready, out_data, k);
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL stream_drain: valid=%b data=%h want 0 0",
               out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0; in_valid = 1; in_data = W'(8'h11);
    tick();
    in_data = W'(8'h22);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== W'(8'h11) || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full: ready=%b valid=%b data=%h want 0 1 11",
               in_ready, out_valid, out_data);
    end
    in_valid = 0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== W'(8'h11)) begin
      failures++;
      $display("FAIL bp_hold: ready=%b data=%h want 0 11", in_ready, out_data);
    end
    out_ready = 1;
    #1;
    checks++;
    if (out_data !== W'(8'h11)) begin
      failures++;
      $display("FAIL bp_first: data=%h want 11", out_data);
    end
    tick();
    checks++;
    if (out_data !== W'(8'h22) || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: ready=%b valid=%b data=%h want 1 1 22",
               in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1; in_valid = 1; in_data = W'(8'h5A);
    tick();
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
        failures++;
        $display("FAIL bubble%0d: valid=%b data=%h want 0 0",
                 k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0; in_valid = 1; in_data = W'(8'h11);
    tick();
    in_data = W'(8'h22);
    tick();
    in_data = W'(8'h33); flush = 1;
    tick();
    flush = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      failures++;
      $display("FAIL flush: valid=%b ready=%b data=%h want 0 1 0",
               out_valid, in_ready, out_data);
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data === W'(8'h33)) begin
        failures++;
        $display("FAIL flush_leak%0d: valid=%b data=%h want 0 0",
                 k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 0; in_valid = 1; in_data = W'(8'h44);
    tick();
    in_data = W'(8'h55);
    tick();
    rst = 1; flush = 1; out_ready = 1;
    tick();
    rst = 0; flush = 0; in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: valid=%b ready=%b data=%h want 0 1 0",
               out_valid, in_ready, out_data);
    end
`ifdef PIPE_SKID_STATS_EN
    checks++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_stats: stall=%0d bubble=%0d want 0 0",
               stall_cnt, bubble_cnt);
    end
`endif
  endtask

`ifdef PIPE_SKID_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 0; in_valid = 1; in_data = W'(8'h66);
    tick();
    in_valid = 0;
    repeat (5) tick();
    out_ready = 1;
    tick();
    repeat (3) tick();
    checks++;
    if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stats: stall=%0d bubble=%0d want 5 3",
               stall_cnt, bubble_cnt);
    end
    flush = 1; out_ready = 0;
    tick();
    flush = 0;
    checks++;
    if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stats_flush: stall=%0d bubble=%0d want 5 3",
               stall_cnt, bubble_cnt);
    end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] d;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int j = 0; j < W / 32; j++) d[j*32 +: 32] = $urandom;
      in_data   = d;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 79) == 0);
      tick();
      checks++;
      if (out_valid !== (q.size() > 0) ||
          in_ready !== (q.size() < 2) ||
          out_data !== ((q.size() > 0) ? q[0] : '0)) begin
        failures++;
        $display("FAIL random%0d: valid=%b ready=%b data=%h want %b %b %h",
                 n, out_valid, in_ready, out_data, q.size() > 0,
                 q.size() < 2, (q.size() > 0) ? q[0] : '0);
      end
`ifdef PIPE_SKID_STATS_EN
      checks++;
      if (stall_cnt !== stall_m || bubble_cnt !== bubble_m) begin
        failures++;
        $display("FAIL random_stats%0d: stall=%0d bubble=%0d want %0d %0d",
                 n, stall_cnt, bubble_cnt, stall_m, bubble_m);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    stall_m  = '0;
    bubble_m = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_mid_reset();
`ifdef PIPE_SKID_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
